// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Two-requester round-robin arbiter owning a 2:1 data mux and a registered
// output stage. A word is taken from the granted source whenever the output
// register is empty or being drained, and is held until the consumer accepts it.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   a_data/a_valid/a_ready - source A valid/ready channel
//   b_data/b_valid/b_ready - source B valid/ready channel
//   c_data/c_valid/c_ready - registered output channel
//   s                   - source of the word held in c_data (0 = A, 1 = B)
//   a_count, b_count    - saturating counts of accepted A / B words
module mux_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] c_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic             s,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic [WIDTH-1:0] c_data_q, c_data_d;
  logic             c_valid_q, c_valid_d;
  logic             s_q, s_d;
  logic             prio_b_q, prio_b_d;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  logic             load;
  logic             grant_a;
  logic             grant_b;
  logic [WIDTH-1:0] mux_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Grant: the output register can load when empty or draining. On a tie the
  // priority flag decides; a lone requester always wins. Reset blocks grants
  // so no ready is seen while rst is high.
  always_comb begin
    load    = !c_valid_q || c_ready;
    grant_a = !rst && load && a_valid && (!b_valid || !prio_b_q);
    grant_b = !rst && load && b_valid && (!a_valid || prio_b_q);
  end

  assign mux_data = grant_b ? b_data : a_data;

  always_comb begin
    c_data_d  = c_data_q;
    c_valid_d = c_valid_q;
    s_d       = s_q;
    prio_b_d  = prio_b_q;
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (load) begin
      if (grant_a || grant_b) begin
        c_data_d  = mux_data;
        c_valid_d = 1'b1;
        s_d       = grant_b;
        // Next tie goes to whichever source did not just win.
        prio_b_d  = grant_a;
      end else begin
        // Drained (or was already empty) with nothing to replace it;
        // data and select keep their last values.
        c_valid_d = 1'b0;
      end
    end
    if (grant_a) a_count_d = sat_inc(a_count_q);
    if (grant_b) b_count_d = sat_inc(b_count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
      s_q       <= 1'b0;
      prio_b_q  <= 1'b0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      c_data_q  <= c_data_d;
      c_valid_q <= c_valid_d;
      s_q       <= s_d;
      prio_b_q  <= prio_b_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign c_data  = c_data_q;
  assign c_valid = c_valid_q;
  assign s       = s_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model and a
// scoreboard queue of expected output words.
module tb_mux_rr_arbiter;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_valid = 1'b1;
  logic             a_ready;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_valid = 1'b1;
  logic             b_ready;
  logic [WIDTH-1:0] c_data;
  logic             c_valid;
  logic             c_ready = 1'b0;
  logic             s;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  mux_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .s(s), .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state of the output register as seen during the
  // current cycle, plus the source of the most recent grant (-1 = none).
  logic             m_occ = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_s = 1'b0;
  int               m_last = -1;
  int               m_ac = 0;
  int               m_bc = 0;

  // Decision taken in the current cycle, applied at the next edge.
  logic             p_rst = 1'b1;
  logic             p_load = 1'b0;
  int               p_gsrc = -1;
  logic [WIDTH-1:0] p_gdata = '0;

  logic             exp_ar = 1'b0;
  logic             exp_br = 1'b0;
  logic             mon_en = 1'b0;

  // Scoreboard entries: {source, data}
  logic [WIDTH:0]   sb[$];

  task automatic cycle(input logic r, input logic av, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [WIDTH-1:0] bd, input logic cr);
    int g;
    @(posedge clk);
    #1;
    // Commit what the previous cycle decided.
    if (p_rst) begin
      m_occ = 1'b0; m_data = '0; m_s = 1'b0; m_last = -1; m_ac = 0; m_bc = 0;
      sb.delete();
    end else if (p_load) begin
      if (p_gsrc >= 0) begin
        m_occ  = 1'b1;
        m_data = p_gdata;
        m_s    = (p_gsrc == 1);
        m_last = p_gsrc;
        if (p_gsrc == 0) m_ac = (m_ac < CNT_MAX) ? m_ac + 1 : CNT_MAX;
        else             m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
      end else begin
        m_occ = 1'b0;
      end
    end
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; c_ready = cr;
    // Decide this cycle: round robin favours the source that did not win last.
    g = -1;
    p_load = !m_occ || cr;
    if (!r && p_load) begin
      if (av && bv)  g = (m_last == 0) ? 1 : 0;
      else if (av)   g = 0;
      else if (bv)   g = 1;
    end
    p_rst   = r;
    p_gsrc  = g;
    p_gdata = (g == 1) ? bd : ad;
    exp_ar  = (g == 0);
    exp_br  = (g == 1);
    if (g >= 0) sb.push_back({(g == 1), p_gdata});
    mon_en = 1'b1;
    #1;
  endtask

  // Monitor: checks live outputs every cycle and retires a scoreboard entry
  // whenever the consumer takes the presented word.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (mon_en) begin
      chk("a_ready", 64'(a_ready), 64'(exp_ar));
      chk("b_ready", 64'(b_ready), 64'(exp_br));
      chk("c_valid", 64'(c_valid), 64'(m_occ));
      chk("c_data_hold", 64'(c_data), 64'(m_data));
      chk("s_hold", 64'(s), 64'(m_s));
      chk("a_count", 64'(a_count), 64'(m_ac));
      chk("b_count", 64'(b_count), 64'(m_bc));
      if (c_valid === 1'b1 && c_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(0), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("sb_data", 64'(c_data), 64'(e[WIDTH-1:0]));
          chk("sb_src", 64'(s), 64'(e[WIDTH]));
        end
      end
    end
  end

  logic             rav, rbv, rcr, rr;
  logic [WIDTH-1:0] rad, rbd;

  initial begin
    // Reset held for three cycles with both sources requesting.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 32'hBF, 1'b1, 32'h09, 1'b0);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);
    end
    chk("rst_c_valid", 64'(c_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_a_count", 64'(a_count), 64'd0);
    chk("rst_b_count", 64'(b_count), 64'd0);

    // Single source A.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, (i < 4), 32'hBF, 1'b0, 32'h0, 1'b1);
      if (i == 1) begin
        chk("single_data", 64'(c_data), 64'hBF);
        chk("single_s", 64'(s), 64'd0);
        chk("single_valid", 64'(c_valid), 64'd1);
      end
      if (i == 4) chk("single_a_count", 64'(a_count), 64'd4);
    end

    // Contention fairness from reset.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, (i < 6), 32'hBF, (i < 6), 32'h09, 1'b1);
      if (i >= 1) begin
        chk("fair_data", 64'(c_data), ((i - 1) % 2 == 0) ? 64'hBF : 64'h09);
        chk("fair_s", 64'(s), 64'((i - 1) % 2));
      end
    end
    chk("fair_a_count", 64'(a_count), 64'd3);
    chk("fair_b_count", 64'(b_count), 64'd3);

    // Back-pressure: FULL with A's word, stall, then B must win next.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'hBF, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'hBF, 1'b1, 32'h09, 1'b0);
      chk("stall_data", 64'(c_data), 64'hBF);
      chk("stall_a_ready", 64'(a_ready), 64'd0);
      chk("stall_b_ready", 64'(b_ready), 64'd0);
    end
    cycle(1'b0, 1'b1, 32'hBF, 1'b1, 32'h09, 1'b1);
    chk("resume_b_ready", 64'(b_ready), 64'd1);
    chk("resume_a_ready", 64'(a_ready), 64'd0);

    // Drain to empty after the B word.
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("drain_data", 64'(c_data), 64'h09);
    chk("drain_s", 64'(s), 64'd1);
    chk("drain_valid1", 64'(c_valid), 64'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("drain_valid0", 64'(c_valid), 64'd0);
    chk("drain_hold_data", 64'(c_data), 64'h09);
    chk("drain_hold_s", 64'(s), 64'd1);

    // Saturation, then reset while FULL.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 32'(i + 16), 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h99, 1'b0, 32'h0, 1'b0);
    chk("sat_a_count", 64'(a_count), 64'd7);
    chk("sat_full", 64'(c_valid), 64'd1);
    chk("sat_data", 64'(c_data), 64'd25);
    cycle(1'b1, 1'b1, 32'h99, 1'b0, 32'h0, 1'b0);
    chk("midrst_a_ready", 64'(a_ready), 64'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("midrst_c_valid", 64'(c_valid), 64'd0);
    chk("midrst_c_data", 64'(c_data), 64'd0);
    chk("midrst_s", 64'(s), 64'd0);
    chk("midrst_a_count", 64'(a_count), 64'd0);
    chk("midrst_b_count", 64'(b_count), 64'd0);

    // Randomized traffic; sources hold valid/data until accepted.
    rav = 1'b0; rbv = 1'b0; rad = '0; rbd = '0;
    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(0, 249) == 0);
      rcr = ($urandom_range(0, 3) != 0);
      if (!rav || exp_ar) begin
        rav = ($urandom_range(0, 2) != 0);
        rad = $urandom;
      end
      if (!rbv || exp_br) begin
        rbv = ($urandom_range(0, 2) != 0);
        rbd = $urandom;
      end
      cycle(rr, rav, rad, rbv, rbd, rcr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
